apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

APB master that shares one APB bus between two requesters, with round-robin arbitration. It drives the APB completer (8-bit address, 8-bit data, PREADY-based wait states) through IDLE/SETUP/ACCESS sequencing. Each request is captured, run as a single APB transfer, and answered with a one-cycle response pulse carrying read data and an error flag. A timeout stops a missing PREADY from hanging the bus.

## Interface
Parameters:
- TIMEOUT, 16: number of ACCESS cycles without PREADY before the transfer is aborted with an error. Legal range is 2..255.

Ports:
- PCLK  in  1  clock. The block uses one clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- req0_valid / req1_valid  in  1  request pending.
- req0_write / req1_write  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  8  target address.
- req0_wdata / req1_wdata  in  8  write data.
- req0_ack / req1_ack  out  1  one-cycle pulse: the request has been captured.
- resp0_valid / resp1_valid  out  1  one-cycle pulse: the transfer has completed.
- resp_rdata  out  8  read data. Valid while any resp valid is high.
- resp_err  out  1  timeout flag. Valid while any resp valid is high.
- busy  out  1  high while the state is not IDLE.
- PSELx, PENABLE, PWRITE  out  1  APB control.
- PADDR, PWDATA  out  8  APB address and write data.
- PRDATA  in  8  APB read data.
- PREADY  in  1  APB ready.

## Operation
- State machine: IDLE, SETUP, ACCESS. The state and all outputs are registered.
- IDLE:
  - PSELx=0, PENABLE=0.
  - If any reqN_valid is high, arbitrate, latch the winner's write/addr/wdata into PWRITE/PADDR/PWDATA, and go to SETUP.
- SETUP:
  - PSELx=1, PENABLE=0.
  - reqN_ack=1 for the granted requester, for this cycle only.
  - Always go to ACCESS on the next edge.
- ACCESS:
  - PSELx=1, PENABLE=1.
  - PADDR, PWRITE and PWDATA are held stable.
  - The timeout counter increments each cycle in which PREADY is low.
- Completion, normal:
  - Condition: PREADY=1 sampled in ACCESS.
  - For a read, capture PRDATA into resp_rdata; for a write, resp_rdata=0.
  - resp_err=0.
- Completion, timeout:
  - Condition: the counter reaches TIMEOUT-1 with PREADY still low.
  - resp_err=1, resp_rdata=0.
- On completion:
  - respN_valid pulses for the owner of the transfer in the following cycle.
  - If any reqN_valid is high at the completion edge, re-arbitrate and go straight to SETUP (PSELx stays 1, PENABLE drops to 0).
  - Otherwise go to IDLE.
- Arbitration:
  - A single request wins.
  - When both requests are high, the requester not granted last wins.
  - The last-grant pointer resets to requester 1, so requester 0 wins the first tie.
- Requester rules:
  - Hold valid and the payload stable until ack is seen.
  - Drop valid, or present the next request, in the cycle after ack.
  - Arbitration samples valid only in IDLE and at a completion edge. A valid still high during SETUP is ignored.
- PREADY is ignored outside ACCESS. This covers a stale PREADY from the completer during SETUP after a back-to-back transfer.
- Reset, asynchronous:
  - Force IDLE and clear the counter.
  - Last-grant pointer = 1.
  - All outputs 0: PSELx, PENABLE, PWRITE, PADDR, PWDATA, acks, resp valids, resp_rdata, resp_err, busy.
  - A transfer in progress is dropped with no response. The requester must reissue it.

## Timing
- Read with a zero-wait completer (PREADY registered one cycle after ACCESS starts):
  - Cycle 0: req valid is sampled at the end of the cycle.
  - Cycle 1: SETUP, ack.
  - Cycle 2: ACCESS.
  - Cycle 3: ACCESS with PREADY=1.
  - Cycle 4: resp valid.
  - Latency from valid to response is 4 cycles.
- Each extra PREADY-low cycle adds one cycle to the latency.
- Back-to-back transfers cost 3 bus cycles each (SETUP plus 2×ACCESS) with no IDLE between them.
- busy falls in the cycle after completion only if the next state is IDLE.
- Timeout: the response arrives TIMEOUT cycles after ACCESS is entered, with resp_err=1.
- resp_rdata and resp_err hold their values until the next completion. Only the valid pulse qualifies them.

## Test plan
- Write then read, single requester:
  - req0 writes 0xA5 to address 0x10, then reads address 0x10.
  - PWDATA=0xA5 throughout SETUP/ACCESS.
  - resp0_valid is high in cycle 4 of each transfer.
  - The read returns resp_rdata=0xA5 with resp_err=0.
- Simultaneous requests:
  - req0 and req1 are both valid from cycle 0, each held continuously.
  - Grants go 0, 1, 0, 1.
  - Transfers run back to back with no IDLE cycle.
  - Each response goes to the owner of its transfer.
- Wait states:
  - A completer model holds PREADY low for 3 extra ACCESS cycles.
  - PADDR, PWDATA and PWRITE stay stable through the whole ACCESS phase.
  - The response arrives at cycle 7.
- Timeout with TIMEOUT=16:
  - PREADY is held at 0.
  - resp0_valid arrives with resp_err=1 and resp_rdata=0, 16 cycles after ACCESS is entered.
  - The bus returns to IDLE.
- Stale PREADY:
  - The completer asserts PREADY during the SETUP of a back-to-back transfer.
  - That PREADY is ignored.
  - The transfer still spends at least one cycle in ACCESS before completing.
- Reset mid-ACCESS:
  - PRESETn is asserted asynchronously during ACCESS.
  - All outputs go to 0 immediately.
  - No response pulse is produced.
  - After reset, the first tie grants req0.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// APB master sharing one bus between two requesters with round-robin arbitration.
// Latency: valid to response is 4 cycles with a zero-wait completer, plus 1 per PREADY-low cycle.
// Backpressure: a requester holds its request until ack; PREADY stretches ACCESS, which ends by timeout after TIMEOUT cycles.
module apb_master_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       req0_valid,
   input  logic       req0_write,
   input  logic [7:0] req0_addr,
   input  logic [7:0] req0_wdata,
   input  logic       req1_valid,
   input  logic       req1_write,
   input  logic [7:0] req1_addr,
   input  logic [7:0] req1_wdata,
   output logic       req0_ack,
   output logic       req1_ack,
   output logic       resp0_valid,
   output logic       resp1_valid,
   output logic [7:0] resp_rdata,
   output logic       resp_err,
   output logic       busy,
   output logic       PSELx,
   output logic       PENABLE,
   output logic       PWRITE,
   output logic [7:0] PADDR,
   output logic [7:0] PWDATA,
   input  logic [7:0] PRDATA,
   input  logic       PREADY
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       last_grant;
   logic       owner;
   logic       any_req;
   logic       grant;
   logic       done;
   logic       launch;

   // grant = 1 selects requester 1; on a tie the one not served last wins
   always_comb begin
      any_req = req0_valid | req1_valid;
      grant   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      done    = (state == ACCESS) && (PREADY || (cnt == CNT_LAST));
      launch  = any_req && ((state == IDLE) || done);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state       <= IDLE;
         cnt         <= '0;
         last_grant  <= 1'b1;
         owner       <= 1'b0;
         req0_ack    <= 1'b0;
         req1_ack    <= 1'b0;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
         busy        <= 1'b0;
         PSELx       <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
      end else begin
         req0_ack    <= 1'b0;
         req1_ack    <= 1'b0;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;

         if (launch) begin
            state      <= SETUP;
            PSELx      <= 1'b1;
            PENABLE    <= 1'b0;
            busy       <= 1'b1;
            PWRITE     <= grant ? req1_write : req0_write;
            PADDR      <= grant ? req1_addr  : req0_addr;
            PWDATA     <= grant ? req1_wdata : req0_wdata;
            owner      <= grant;
            last_grant <= grant;
            req0_ack   <= ~grant;
            req1_ack   <= grant;
         end else if (state == SETUP) begin
            state   <= ACCESS;
            PENABLE <= 1'b1;
            cnt     <= '0;
         end else if (done) begin
            state   <= IDLE;
            PSELx   <= 1'b0;
            PENABLE <= 1'b0;
            busy    <= 1'b0;
         end else if (state == ACCESS) begin
            cnt <= cnt + 8'd1;
         end

         // a completion without PREADY is a timeout: flag it and return no data
         if (done) begin
            resp0_valid <= ~owner;
            resp1_valid <= owner;
            resp_err    <= ~PREADY;
            resp_rdata  <= (PREADY && !PWRITE) ? PRDATA : 8'h00;
         end
      end
   end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: vector table, directed corner sequences, and a
// randomized run scored against a transaction-level model of bus order and memory.
module tb_apb_master_arbiter;
   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       req0_valid = 1'b0, req0_write = 1'b0;
   logic [7:0] req0_addr = '0, req0_wdata = '0;
   logic       req1_valid = 1'b0, req1_write = 1'b0;
   logic [7:0] req1_addr = '0, req1_wdata = '0;
   logic       req0_ack, req1_ack, resp0_valid, resp1_valid;
   logic [7:0] resp_rdata;
   logic       resp_err, busy, PSELx, PENABLE, PWRITE;
   logic [7:0] PADDR, PWDATA;
   logic [7:0] PRDATA = '0;
   logic       PREADY = 1'b0;

   int n_cmp = 0;
   int n_fail = 0;

   apb_master_arbiter #(.TIMEOUT(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req0_ack(req0_ack), .req1_ack(req1_ack), .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
      .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   // completer: PREADY decided at negedge for the next rising edge
   int         waits = 0;
   bit         hang = 1'b0, stale = 1'b0, rand_waits = 1'b0;
   int         idx = 0, cur_waits = 0;
   logic [7:0] dev_mem [256] = '{default: 8'h00};

   always @(negedge PCLK) begin
      if (!PRESETn) begin
         idx = 0;
         PREADY = 1'b0;
      end else if (PSELx && PENABLE) begin
         idx++;
         if (!hang && idx > cur_waits + 1) begin
            PREADY = 1'b1;
            PRDATA = dev_mem[PADDR];
            if (PWRITE) dev_mem[PADDR] = PWDATA;
         end else begin
            PREADY = 1'b0;
         end
      end else begin
         idx = 0;
         PREADY = stale && PSELx;
         cur_waits = rand_waits ? int'($urandom_range(0, 3)) : waits;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({PSELx, PENABLE, PWRITE, PADDR, PWDATA, req0_ack, req1_ack, resp0_valid,
                  resp1_valid, resp_rdata, resp_err, busy});
   endfunction

   task automatic set_req(input bit p, input logic vl, input logic wr, input logic [7:0] a, input logic [7:0] d);
      if (p) begin
         req1_valid = vl; req1_write = wr; req1_addr = a; req1_wdata = d;
      end else begin
         req0_valid = vl; req0_write = wr; req0_addr = a; req0_wdata = d;
      end
   endtask

   typedef struct {
      bit         port;
      bit         wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         waits;
      bit         hang;
      logic [7:0] exp_rd;
      bit         exp_err;
      int         exp_lat;
   } vec_t;

   task automatic run_vec(input vec_t t, input int n);
      int    cyc;
      bit    got_resp, stable;
      string nm;
      nm = $sformatf("vec%0d", n);
      @(negedge PCLK);
      waits = t.waits;
      hang  = t.hang;
      set_req(t.port, 1'b1, t.wr, t.addr, t.wdata);
      cyc = 0; got_resp = 0; stable = 1;
      while (!got_resp && cyc < 40) begin
         @(posedge PCLK); #1;
         cyc++;
         if (cyc == 1) check({nm, " setup/ack"}, 64'({req1_ack, req0_ack, PSELx, PENABLE}),
                             64'({t.port, ~t.port, 2'b10}));
         if (cyc == 2) check({nm, " access"}, 64'({PSELx, PENABLE}), 64'(2'b11));
         if (req0_ack || req1_ack) set_req(t.port, 1'b0, t.wr, t.addr, t.wdata);
         if (PSELx && (PADDR !== t.addr || PWRITE !== t.wr || (t.wr && PWDATA !== t.wdata))) stable = 0;
         if (resp0_valid || resp1_valid) begin
            got_resp = 1;
            check({nm, " latency"}, 64'(cyc), 64'(t.exp_lat));
            check({nm, " owner"}, 64'({resp1_valid, resp0_valid}), 64'({t.port, ~t.port}));
            check({nm, " rdata"}, 64'(resp_rdata), 64'(t.exp_rd));
            check({nm, " err"}, 64'(resp_err), 64'(t.exp_err));
            check({nm, " idle after"}, 64'({busy, PSELx, PENABLE}), 64'(0));
         end
      end
      check({nm, " payload stable"}, 64'(stable), 64'(1));
      check({nm, " response seen"}, 64'(got_resp), 64'(1));
      set_req(t.port, 1'b0, t.wr, t.addr, t.wdata);
      hang = 1'b0;
   endtask

   // both requesters read continuously; collects nx grants/responses
   task automatic run_pair(input int nx, input string nm, input bit chk_gap);
      int cyc, nack, nresp;
      bit gap;
      bit gr[4], own[4];
      logic [7:0] rd[4];
      int ac[4], rc[4];
      @(negedge PCLK);
      waits = 0;
      set_req(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
      set_req(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
      cyc = 0; nack = 0; nresp = 0; gap = 0;
      while (nresp < nx && cyc < 80) begin
         @(posedge PCLK); #1;
         cyc++;
         if (resp0_valid || resp1_valid) begin
            own[nresp] = resp1_valid; rd[nresp] = resp_rdata; rc[nresp] = cyc; nresp++;
         end
         if (nack > 0 && nresp < nx && !PSELx) gap = 1;
         if ((req0_ack || req1_ack) && nack < nx) begin
            gr[nack] = req1_ack; ac[nack] = cyc; nack++;
            if (nack == nx) begin
               set_req(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
               set_req(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
            end
         end
      end
      set_req(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
      set_req(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
      check({nm, " responses"}, 64'(nresp), 64'(nx));
      if (nresp == nx) begin
         for (int i = 0; i < nx; i++) begin
            check($sformatf("%s grant%0d", nm, i), 64'(gr[i]), 64'(i % 2));
            check($sformatf("%s owner%0d", nm, i), 64'(own[i]), 64'(i % 2));
            check($sformatf("%s rdata%0d", nm, i), 64'(rd[i]), (i % 2) ? 64'(8'h3C) : 64'(8'hA5));
            check($sformatf("%s ack-to-resp%0d", nm, i), 64'(rc[i] - ac[i]), 64'(3));
         end
         if (chk_gap) begin
            check({nm, " first resp cycle"}, 64'(rc[0]), 64'(4));
            check({nm, " no idle gap"}, 64'(gap), 64'(0));
         end
      end
   endtask

   typedef struct { bit own; logic [7:0] rd; } exp_t;

   initial begin
      vec_t       tbl[8];
      exp_t       q[$];
      exp_t       e;
      logic [7:0] model_mem [256];
      logic [1:0] dv;
      bit         acked[2];
      bit         m_last, g, gen, cur_v, wr;
      logic [7:0] a, d;
      int         nresp, cyc;

      tbl[0] = '{0, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 0, 4};
      tbl[1] = '{0, 0, 8'h10, 8'h00, 0, 0, 8'hA5, 0, 4};
      tbl[2] = '{1, 1, 8'hFF, 8'h3C, 3, 0, 8'h00, 0, 7};
      tbl[3] = '{0, 0, 8'hFF, 8'h00, 3, 0, 8'h3C, 0, 7};
      tbl[4] = '{1, 0, 8'h10, 8'h00, 1, 0, 8'hA5, 0, 5};
      tbl[5] = '{0, 0, 8'h00, 8'h00, 2, 0, 8'h00, 0, 6};
      tbl[6] = '{0, 1, 8'h20, 8'h77, 0, 1, 8'h00, 1, 18};
      tbl[7] = '{1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 0, 4};

      repeat (3) @(posedge PCLK);
      #1 check("reset outputs", all_outs(), 64'(0));
      @(negedge PCLK) PRESETn = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

      run_pair(4, "pair", 1'b1);
      stale = 1'b1;
      run_pair(2, "stale", 1'b0);
      stale = 1'b0;

      // asynchronous reset while a transfer sits in ACCESS
      @(negedge PCLK);
      hang = 1'b1;
      set_req(1'b0, 1'b1, 1'b1, 8'h30, 8'h55);
      for (int i = 0; i < 3; i++) begin
         @(posedge PCLK); #1;
         if (req0_ack) set_req(1'b0, 1'b0, 1'b1, 8'h30, 8'h55);
      end
      check("rst pre access", 64'({PSELx, PENABLE}), 64'(2'b11));
      #2 PRESETn = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      #1 check("rst async outputs", all_outs(), 64'(0));
      nresp = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge PCLK); #1;
         if (resp0_valid || resp1_valid) nresp++;
         if (i == 2) begin
            @(negedge PCLK);
            hang = 1'b0;
            PRESETn = 1'b1;
         end
      end
      check("rst no response", 64'(nresp), 64'(0));
      check("rst idle", 64'({busy, PSELx}), 64'(0));
      @(negedge PCLK);
      set_req(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
      set_req(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
      @(posedge PCLK); #1;
      check("rst first tie", 64'({req1_ack, req0_ack}), 64'(2'b01));
      set_req(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
      set_req(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
      cyc = 0;
      while (!(resp0_valid || resp1_valid) && cyc < 10) begin
         @(posedge PCLK); #1;
         cyc++;
      end
      check("rst tie resp", 64'({resp1_valid, resp0_valid, resp_rdata}), 64'({2'b01, 8'hA5}));

      // randomized run against a transaction-order model
      @(negedge PCLK) PRESETn = 1'b0;
      @(negedge PCLK) PRESETn = 1'b1;
      m_last = 1'b1;
      for (int i = 0; i < 256; i++) model_mem[i] = dev_mem[i];
      rand_waits = 1'b1;
      acked[0] = 0; acked[1] = 0;
      for (int c = 0; c < 3300; c++) begin
         gen = (c < 3000);
         @(negedge PCLK);
         for (int p = 0; p < 2; p++) begin
            cur_v = p ? req1_valid : req0_valid;
            if (!cur_v || acked[p]) begin
               if (gen && $urandom_range(0, 2) != 0)
                  set_req(1'(p), 1'b1, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)), 8'($urandom));
               else
                  set_req(1'(p), 1'b0, 1'b0, 8'h00, 8'h00);
               acked[p] = 0;
            end
         end
         dv = {req1_valid, req0_valid};
         @(posedge PCLK); #1;
         if (req0_ack || req1_ack) begin
            if (dv == 2'b00) begin
               check("rand spurious ack", 64'({req1_ack, req0_ack}), 64'(0));
            end else begin
               g = (dv == 2'b11) ? ~m_last : dv[1];
               check("rand grant", 64'({req1_ack, req0_ack}), g ? 64'(2'b10) : 64'(2'b01));
               wr = g ? req1_write : req0_write;
               a  = g ? req1_addr  : req0_addr;
               d  = g ? req1_wdata : req0_wdata;
               e.own = g;
               e.rd  = wr ? 8'h00 : model_mem[a];
               if (wr) model_mem[a] = d;
               q.push_back(e);
               m_last = g;
            end
         end
         acked[0] = req0_ack;
         acked[1] = req1_ack;
         if (resp0_valid || resp1_valid) begin
            if (q.size() == 0) begin
               check("rand spurious resp", 64'({resp1_valid, resp0_valid}), 64'(0));
            end else begin
               e = q.pop_front();
               check("rand owner", 64'({resp1_valid, resp0_valid}), 64'({e.own, ~e.own}));
               check("rand rdata", 64'(resp_rdata), 64'(e.rd));
               check("rand err", 64'(resp_err), 64'(0));
            end
         end
      end
      check("rand drained", 64'(q.size()), 64'(0));
      check("rand final idle", 64'({busy, req1_valid, req0_valid}), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
